// File: rtl/fetch_if.sv
// Fetch-stage bundle: pipeline control and redirects in, memory address and IF/ID register out.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_index, instruction,
    output read_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
           fault, fault_pc, fetch_count
  );

  modport master (
    output stall, branch_taken, branch_target, jump, jump_index, instruction,
    input  read_address, if_id_instruction, if_id_pc_plus4, if_id_valid,
           fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, next-PC selection with legality check,
// IF/ID pipeline register and a sticky fault state for illegal fetch addresses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input logic    clk,
  input logic    rst,
  fetch_if.slave bus
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] jump_addr_s;
  logic [31:0] cand_s;
  logic        redirect_s;
  logic        legal_s;

  // Next-PC candidate and its legality, then the per-edge state update.
  always_comb begin
    pc_plus4_s  = pc_q + 32'd4;
    jump_addr_s = {pc_plus4_s[31:28], bus.jump_index, 2'b00};
    redirect_s  = bus.branch_taken | bus.jump;
    if (bus.branch_taken) begin
      cand_s = bus.branch_target;
    end else if (bus.jump) begin
      cand_s = jump_addr_s;
    end else begin
      cand_s = pc_plus4_s;
    end
    legal_s = (cand_s[1:0] == 2'b00) && (cand_s <= LAST_PC);

    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    case (state_q)
      RUN: begin
        if (redirect_s) begin
          valid_d = 1'b0;
          if (!legal_s) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = cand_s;
          end else begin
            pc_d    = cand_s;
            instr_d = 32'd0;
          end
        end else if (bus.stall) begin
          valid_d = valid_q;
        end else begin
          // The last legal word is still delivered on the edge that faults on advance.
          instr_d = bus.instruction;
          pc4_d   = pc_plus4_s;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (!legal_s) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = cand_s;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = FAULT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // State and pipeline registers; only reset leaves FAULT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign bus.read_address      = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc_plus4    = pc4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.fault             = fault_q;
  assign bus.fault_pc          = fault_pc_q;
  assign bus.fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned MEM_BYTES = 32;

  logic        clk;
  logic        rst;
  logic [31:0] mem [8];
  int          vectors;
  int          miscompares;

  // Reference model state (used by the randomized test).
  logic [31:0] m_pc, m_instr, m_pc4, m_fpc, m_cnt;
  logic        m_valid, m_fault;

  fetch_if bif ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory answers combinationally.
  always_comb bif.instruction = mem[bif.read_address[4:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.stall         = 1'b0;
    bif.branch_taken  = 1'b0;
    bif.branch_target = 32'd0;
    bif.jump          = 1'b0;
    bif.jump_index    = 26'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2;
    vectors++;
    if (bif.read_address !== 32'd0 || bif.if_id_instruction !== 32'd0 || bif.if_id_pc_plus4 !== 32'd0 ||
        bif.if_id_valid !== 1'b0 || bif.fault !== 1'b0 || bif.fault_pc !== 32'd0 || bif.fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_values: pc=%h ins=%h p4=%h v=%b f=%b fpc=%h cnt=%0d expected all zero",
               bif.read_address, bif.if_id_instruction, bif.if_id_pc_plus4, bif.if_id_valid,
               bif.fault, bif.fault_pc, bif.fetch_count);
    end
    tick();
    vectors++;
    if (bif.read_address !== 32'd0 || bif.if_id_valid !== 1'b0 || bif.fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_held: pc=%h v=%b cnt=%0d expected 0/0/0", bif.read_address, bif.if_id_valid, bif.fetch_count);
    end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (bif.read_address !== 32'(4 * i) || bif.if_id_pc_plus4 !== 32'(4 * i) ||
          bif.if_id_instruction !== mem[i - 1] || bif.if_id_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_edge%0d: pc=%h p4=%h ins=%h v=%b expected pc=%h p4=%h ins=%h v=1", i,
                 bif.read_address, bif.if_id_pc_plus4, bif.if_id_instruction, bif.if_id_valid,
                 32'(4 * i), 32'(4 * i), mem[i - 1]);
      end
    end
    vectors++;
    if (bif.fetch_count !== 32'd4) begin
      miscompares++;
      $display("FAIL seq_count: got %0d expected 4", bif.fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    bif.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (bif.read_address !== 32'd8 || bif.if_id_pc_plus4 !== 32'd8 || bif.if_id_instruction !== mem[1] ||
          bif.if_id_valid !== 1'b1 || bif.fetch_count !== 32'd2) begin
        miscompares++;
        $display("FAIL stall_hold%0d: pc=%h p4=%h ins=%h v=%b cnt=%0d expected pc=8 p4=8 ins=%h v=1 cnt=2", i,
                 bif.read_address, bif.if_id_pc_plus4, bif.if_id_instruction, bif.if_id_valid, bif.fetch_count, mem[1]);
      end
    end
    bif.stall = 1'b0;
    tick();
    vectors++;
    if (bif.read_address !== 32'd12 || bif.if_id_instruction !== mem[2] || bif.fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_release: pc=%h ins=%h cnt=%0d expected pc=12 ins=%h cnt=3",
               bif.read_address, bif.if_id_instruction, bif.fetch_count, mem[2]);
    end
  endtask

  task automatic test_branch_over_stall();
    do_reset();
    tick();
    tick();
    bif.stall         = 1'b1;
    bif.branch_taken  = 1'b1;
    bif.branch_target = 32'd20;
    tick();
    clear_inputs();
    vectors++;
    if (bif.read_address !== 32'd20 || bif.if_id_valid !== 1'b0 || bif.if_id_instruction !== 32'd0 ||
        bif.fetch_count !== 32'd2) begin
      miscompares++;
      $display("FAIL branch_bubble: pc=%h v=%b ins=%h cnt=%0d expected pc=20 v=0 ins=0 cnt=2",
               bif.read_address, bif.if_id_valid, bif.if_id_instruction, bif.fetch_count);
    end
    tick();
    vectors++;
    if (bif.if_id_pc_plus4 !== 32'd24 || bif.if_id_valid !== 1'b1 || bif.if_id_instruction !== mem[5] ||
        bif.read_address !== 32'd24) begin
      miscompares++;
      $display("FAIL branch_target_fetch: p4=%h v=%b ins=%h pc=%h expected p4=24 v=1 ins=%h pc=24",
               bif.if_id_pc_plus4, bif.if_id_valid, bif.if_id_instruction, bif.read_address, mem[5]);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    bif.jump          = 1'b1;
    bif.jump_index    = 26'd2;
    bif.branch_taken  = 1'b1;
    bif.branch_target = 32'd12;
    tick();
    clear_inputs();
    vectors++;
    if (bif.read_address !== 32'd12) begin
      miscompares++;
      $display("FAIL branch_over_jump: pc=%h expected 0000000c", bif.read_address);
    end
    bif.jump       = 1'b1;
    bif.jump_index = 26'd6;
    tick();
    clear_inputs();
    vectors++;
    if (bif.read_address !== 32'd24 || bif.if_id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_alone: pc=%h v=%b expected pc=24 v=0", bif.read_address, bif.if_id_valid);
    end
  endtask

  task automatic test_misaligned_fault();
    do_reset();
    tick();
    bif.branch_taken  = 1'b1;
    bif.branch_target = 32'd6;
    tick();
    clear_inputs();
    vectors++;
    if (bif.fault !== 1'b1 || bif.fault_pc !== 32'd6 || bif.if_id_valid !== 1'b0 ||
        bif.read_address !== 32'd4 || bif.fetch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL misalign_fault: f=%b fpc=%h v=%b pc=%h cnt=%0d expected f=1 fpc=6 v=0 pc=4 cnt=1",
               bif.fault, bif.fault_pc, bif.if_id_valid, bif.read_address, bif.fetch_count);
    end
    bif.branch_taken  = 1'b1;
    bif.branch_target = 32'd16;
    tick();
    bif.branch_taken = 1'b0;
    bif.jump         = 1'b1;
    bif.jump_index   = 26'd3;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (bif.fault !== 1'b1 || bif.fault_pc !== 32'd6 || bif.if_id_valid !== 1'b0 ||
        bif.read_address !== 32'd4 || bif.fetch_count !== 32'd1) begin
      miscompares++;
      $display("FAIL fault_sticky: f=%b fpc=%h v=%b pc=%h cnt=%0d expected f=1 fpc=6 v=0 pc=4 cnt=1",
               bif.fault, bif.fault_pc, bif.if_id_valid, bif.read_address, bif.fetch_count);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bif.read_address !== 32'd0 || bif.fault !== 1'b0 || bif.fault_pc !== 32'd0 ||
        bif.fetch_count !== 32'd0 || bif.if_id_pc_plus4 !== 32'd0 || bif.if_id_instruction !== 32'd0) begin
      miscompares++;
      $display("FAIL fault_async_reset: pc=%h f=%b fpc=%h cnt=%0d p4=%h ins=%h expected all zero",
               bif.read_address, bif.fault, bif.fault_pc, bif.fetch_count, bif.if_id_pc_plus4, bif.if_id_instruction);
    end
    rst = 1'b1;
  endtask

  task automatic test_end_of_memory();
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (bif.read_address !== 32'd28 || bif.fault !== 1'b0) begin
      miscompares++;
      $display("FAIL eom_reach: pc=%h f=%b expected pc=28 f=0", bif.read_address, bif.fault);
    end
    tick();
    vectors++;
    if (bif.if_id_valid !== 1'b1 || bif.if_id_instruction !== mem[7] || bif.if_id_pc_plus4 !== 32'd32 ||
        bif.fault !== 1'b1 || bif.fault_pc !== 32'd32 || bif.read_address !== 32'd28 || bif.fetch_count !== 32'd8) begin
      miscompares++;
      $display("FAIL eom_last_word: v=%b ins=%h p4=%h f=%b fpc=%h pc=%h cnt=%0d expected v=1 ins=%h p4=32 f=1 fpc=32 pc=28 cnt=8",
               bif.if_id_valid, bif.if_id_instruction, bif.if_id_pc_plus4, bif.fault, bif.fault_pc,
               bif.read_address, bif.fetch_count, mem[7]);
    end
    tick();
    vectors++;
    if (bif.if_id_valid !== 1'b0 || bif.fault !== 1'b1 || bif.read_address !== 32'd28 || bif.fetch_count !== 32'd8) begin
      miscompares++;
      $display("FAIL eom_after: v=%b f=%b pc=%h cnt=%0d expected v=0 f=1 pc=28 cnt=8",
               bif.if_id_valid, bif.fault, bif.read_address, bif.fetch_count);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0; m_fpc = 32'd0; m_cnt = 32'd0;
    m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // One clock edge of the fetch rules, from the inputs currently applied.
  task automatic model_step();
    logic [31:0] seq;
    logic [31:0] tgt;
    if (m_fault) begin
      m_valid = 1'b0;
      return;
    end
    seq = m_pc + 32'd4;
    if (bif.branch_taken || bif.jump) begin
      tgt = bif.branch_taken ? bif.branch_target : ((seq & 32'hF000_0000) | (32'(bif.jump_index) * 32'd4));
      m_valid = 1'b0;
      if ((tgt % 32'd4) != 32'd0 || tgt > 32'(MEM_BYTES - 4)) begin
        m_fault = 1'b1;
        m_fpc   = tgt;
      end else begin
        m_pc    = tgt;
        m_instr = 32'd0;
      end
    end else if (!bif.stall) begin
      m_instr = mem[m_pc / 32'd4];
      m_pc4   = seq;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      if (seq > 32'(MEM_BYTES - 4)) begin
        m_fault = 1'b1;
        m_fpc   = seq;
      end else begin
        m_pc = seq;
      end
    end
  endtask

  task automatic test_random();
    int fault_age;
    do_reset();
    model_reset();
    fault_age = 0;
    for (int n = 0; n < 600; n++) begin
      if ((m_fault && fault_age >= 3) || $urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        clear_inputs();
        #2;
        vectors++;
        if (bif.read_address !== 32'd0 || bif.if_id_valid !== 1'b0 || bif.fault !== 1'b0 || bif.fetch_count !== 32'd0) begin
          miscompares++;
          $display("FAIL rand_async_reset n=%0d: pc=%h v=%b f=%b cnt=%0d expected zeros",
                   n, bif.read_address, bif.if_id_valid, bif.fault, bif.fetch_count);
        end
        rst = 1'b1;
        model_reset();
        fault_age = 0;
      end
      bif.stall         = ($urandom_range(0, 3) == 0);
      bif.branch_taken  = ($urandom_range(0, 9) == 0);
      bif.branch_target = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 9) * 4) : 32'($urandom_range(0, 40));
      bif.jump          = ($urandom_range(0, 9) == 0);
      bif.jump_index    = ($urandom_range(0, 19) == 0) ? 26'($urandom) : 26'($urandom_range(0, 7));
      model_step();
      tick();
      if (m_fault) fault_age++;
      vectors++;
      if (bif.read_address !== m_pc || bif.if_id_instruction !== m_instr || bif.if_id_pc_plus4 !== m_pc4 ||
          bif.if_id_valid !== m_valid || bif.fault !== m_fault || bif.fault_pc !== m_fpc || bif.fetch_count !== m_cnt) begin
        miscompares++;
        $display("FAIL rand_step n=%0d: pc=%h ins=%h p4=%h v=%b f=%b fpc=%h cnt=%0d expected pc=%h ins=%h p4=%h v=%b f=%b fpc=%h cnt=%0d",
                 n, bif.read_address, bif.if_id_instruction, bif.if_id_pc_plus4, bif.if_id_valid, bif.fault,
                 bif.fault_pc, bif.fetch_count, m_pc, m_instr, m_pc4, m_valid, m_fault, m_fpc, m_cnt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_branch_priority();
    test_misaligned_fault();
    test_end_of_memory();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
